data_mem_arbiter: RTL and testbench

//  Shares the single-port data_memory between two requesters: m0 (core load/store unit) and m1 (debug/loader port).

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/rr_arb2.sv | 42 ++++
 rtl/data_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory path: access sizes, bus payloads and the alignment check.
package dmem_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // Request payload presented by a requester.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      size;
    logic            uns;
    logic            we;
  } dmem_req_t;

  // Registered response returned to a requester.
  typedef struct packed {
    logic            valid;
    logic            err;
    logic [XLEN-1:0] rdata;
  } dmem_rsp_t;

  // True for an illegal size or an address not aligned to the access size.
  function automatic logic dmem_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      SIZE_ILL:  bad = 1'b1;
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on conflict, or fixed priority to requester 0.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       fixed,
  output logic [1:0] gnt
);

  // rr_last = 1 means requester 1 was served last, so requester 0 wins the next conflict.
  logic rr_last_q;
  logic rr_last_d;

  // Grant selection from the current requests and round-robin history.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (fixed || rr_last_q) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // History only advances on a cycle that actually grants someone.
  always_comb begin
    rr_last_d = rr_last_q;
    if (gnt != 2'b00) begin
      rr_last_d = gnt[1];
    end
  end

  // Round-robin history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the LSU (m0) and the debug/loader port (m1).
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter bit FIXED_PRIO      = 1'b0,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_size,
  input  logic        m0_unsigned,
  input  logic        m0_we,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_size,
  input  logic        m1_unsigned,
  input  logic        m1_we,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  logic [1:0]           req;
  logic [1:0]           gnt;
  dmem_req_t            m0_pl;
  dmem_req_t            m1_pl;
  dmem_req_t            sel_pl;
  logic                 illegal;
  dmem_rsp_t [1:0]      rsp_q;
  dmem_rsp_t [1:0]      rsp_d;

  assign req = {m1_req, m0_req};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .fixed (FIXED_PRIO),
    .gnt   (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  assign m0_pl = {m0_addr, m0_wdata, m0_size, m0_unsigned, m0_we};
  assign m1_pl = {m1_addr, m1_wdata, m1_size, m1_unsigned, m1_we};

  // Payload mux; an idle bus parks at zero with a word-sized access.
  always_comb begin
    sel_pl      = '0;
    sel_pl.size = SIZE_WORD;
    if (gnt[0]) begin
      sel_pl = m0_pl;
    end else if (gnt[1]) begin
      sel_pl = m1_pl;
    end
  end

  // Legality check on the granted access; disabled entirely when checking is off.
  always_comb begin
    illegal = 1'b0;
    if (ERR_ON_MISALIGN && (gnt != 2'b00)) begin
      illegal = dmem_misaligned(sel_pl.addr[1:0], sel_pl.size);
    end
  end

  assign mem_a        = sel_pl.addr;
  assign mem_wd       = sel_pl.wdata;
  assign mem_size     = sel_pl.size;
  assign mem_unsigned = sel_pl.uns;
  // Write strobe never escapes for a rejected access or while in reset.
  assign mem_we       = sel_pl.we & ~illegal & ~rst;

  // Next response per requester: a grant produces a one-cycle response pulse.
  always_comb begin
    rsp_d = rsp_q;
    for (int i = 0; i < 2; i++) begin
      rsp_d[i].valid = gnt[i];
      rsp_d[i].err   = gnt[i] & illegal;
      if (gnt[i]) begin
        rsp_d[i].rdata = (illegal || sel_pl.we) ? 32'h0 : mem_rd;
      end
    end
  end

  // Response registers; reset drops any response in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign m0_rvalid = rsp_q[0].valid;
  assign m0_err    = rsp_q[0].err;
  assign m0_rdata  = rsp_q[0].rdata;
  assign m1_rvalid = rsp_q[1].valid;
  assign m1_err    = rsp_q[1].err;
  assign m1_rdata  = rsp_q[1].rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a byte-addressed memory model on the memory pins.
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_unsigned, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [1:0]  m0_size;
  logic        m1_req, m1_unsigned, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [1:0]  m1_size;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [1:0]  mem_size;
  logic        mem_unsigned, mem_we;

  logic        fp_m0_gnt, fp_m0_rvalid, fp_m0_err;
  logic [31:0] fp_m0_rdata;
  logic        fp_m1_gnt, fp_m1_rvalid, fp_m1_err;
  logic [31:0] fp_m1_rdata;
  logic [31:0] fp_mem_a, fp_mem_wd;
  logic [1:0]  fp_mem_size;
  logic        fp_mem_unsigned, fp_mem_we;
  wire  [31:0] fp_mem_rd = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  rsp_t q0[$];
  rsp_t q1[$];
  rsp_t exp0, exp1;
  logic pend0, pend1;
  logic g0, g1, fg0, fg1, we_s;
  logic [31:0] a_s, wd_s;
  logic [1:0]  size_s;

  logic [7:0] mem [0:255];

  data_mem_arbiter #(.FIXED_PRIO(1'b0), .ERR_ON_MISALIGN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_unsigned(m0_unsigned), .m0_we(m0_we), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_unsigned(m1_unsigned), .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_we(mem_we), .mem_rd(mem_rd)
  );

  data_mem_arbiter #(.FIXED_PRIO(1'b1), .ERR_ON_MISALIGN(1'b1)) u_dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_unsigned(m0_unsigned), .m0_we(m0_we), .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid),
    .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_unsigned(m1_unsigned), .m1_we(m1_we), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid),
    .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
    .mem_a(fp_mem_a), .mem_wd(fp_mem_wd), .mem_size(fp_mem_size), .mem_unsigned(fp_mem_unsigned),
    .mem_we(fp_mem_we), .mem_rd(fp_mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian memory model: combinational read with extension, write on posedge.
  always_comb begin
    logic [7:0] a;
    a = mem_a[7:0];
    case (mem_size)
      2'b00:   mem_rd = mem_unsigned ? {24'h0, mem[a]} : {{24{mem[a][7]}}, mem[a]};
      2'b01:   mem_rd = mem_unsigned ? {16'h0, mem[a+8'd1], mem[a]}
                                     : {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
      default: mem_rd = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_size)
        2'b00: mem[mem_a[7:0]] <= mem_wd[7:0];
        2'b01: begin
          mem[mem_a[7:0]]       <= mem_wd[7:0];
          mem[mem_a[7:0]+8'd1]  <= mem_wd[15:8];
        end
        default: begin
          mem[mem_a[7:0]]       <= mem_wd[7:0];
          mem[mem_a[7:0]+8'd1]  <= mem_wd[15:8];
          mem[mem_a[7:0]+8'd2]  <= mem_wd[23:16];
          mem[mem_a[7:0]+8'd3]  <= mem_wd[31:24];
        end
      endcase
    end
  end

  task automatic drv0(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns, input logic we,
                      input logic e_err, input logic [31:0] e_rdata);
    m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_size = size;
    m0_unsigned = uns; m0_we = we;
    exp0.err = e_err; exp0.rdata = e_rdata;
  endtask

  task automatic drv1(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns, input logic we,
                      input logic e_err, input logic [31:0] e_rdata);
    m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_size = size;
    m1_unsigned = uns; m1_we = we;
    exp1.err = e_err; exp1.rdata = e_rdata;
  endtask

  // One clock: score responses at negedge, capture grants/bus, push expectations, then step.
  task automatic clk_step();
    rsp_t r;
    @(negedge clk);
    n_checks++;
    if (m0_rvalid !== pend0) begin
      n_fail++; $display("FAIL m0_rvalid got=%b exp=%b t=%0t", m0_rvalid, pend0, $time);
    end
    if (m0_rvalid === 1'b1) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++; $display("FAIL m0_rsp unexpected t=%0t", $time);
      end else begin
        r = q0.pop_front();
        if ({m0_err, m0_rdata} !== {r.err, r.rdata}) begin
          n_fail++;
          $display("FAIL m0_rsp got err=%b rdata=%h exp err=%b rdata=%h t=%0t",
                   m0_err, m0_rdata, r.err, r.rdata, $time);
        end
      end
    end
    n_checks++;
    if (m1_rvalid !== pend1) begin
      n_fail++; $display("FAIL m1_rvalid got=%b exp=%b t=%0t", m1_rvalid, pend1, $time);
    end
    if (m1_rvalid === 1'b1) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++; $display("FAIL m1_rsp unexpected t=%0t", $time);
      end else begin
        r = q1.pop_front();
        if ({m1_err, m1_rdata} !== {r.err, r.rdata}) begin
          n_fail++;
          $display("FAIL m1_rsp got err=%b rdata=%h exp err=%b rdata=%h t=%0t",
                   m1_err, m1_rdata, r.err, r.rdata, $time);
        end
      end
    end
    g0 = m0_gnt; g1 = m1_gnt; fg0 = fp_m0_gnt; fg1 = fp_m1_gnt;
    we_s = mem_we; a_s = mem_a; wd_s = mem_wd; size_s = mem_size;
    pend0 = m0_gnt; pend1 = m1_gnt;
    if (m0_gnt === 1'b1) q0.push_back(exp0);
    if (m1_gnt === 1'b1) q1.push_back(exp1);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drv0(1'b1, 32'h0, 32'h11111111, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0);
    drv1(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    n_checks++;
    if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {m0_rvalid, m1_rvalid, m0_err, m1_err});
    end
    n_checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata});
    end
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we);
    end
    m0_req = 1'b0; m0_we = 1'b0;
    #1;
    n_checks++;
    if ({mem_a, mem_size} !== {32'h0, 2'b10}) begin
      n_fail++; $display("FAIL idle_bus got a=%h size=%b exp a=0 size=10", mem_a, mem_size);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    drv0(1'b1, 32'h0, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0);
    clk_step();
    n_checks++;
    if ({g0, g1, we_s} !== 3'b101) begin
      n_fail++; $display("FAIL store_gnt got g0g1we=%b exp=101", {g0, g1, we_s});
    end
    n_checks++;
    if ({a_s, wd_s} !== {32'h0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL store_bus got a=%h wd=%h exp a=0 wd=deadbeef", a_s, wd_s);
    end
    drv0(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    clk_step();
    n_checks++;
    if ({g0, we_s} !== 2'b10) begin
      n_fail++; $display("FAIL load_gnt got g0we=%b exp=10", {g0, we_s});
    end
    m0_req = 1'b0;
    clk_step();
  endtask

  task automatic test_round_robin();
    drv1(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    clk_step();
    m1_req = 1'b0;
    drv0(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    drv1(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      clk_step();
      n_checks++;
      if ({g0, g1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_gnt cycle %0d got g0g1=%b exp=%b", i, {g0, g1},
                           (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      n_checks++;
      if ({fg0, fg1} !== 2'b10) begin
        n_fail++; $display("FAIL fixed_gnt cycle %0d got g0g1=%b exp=10", i, {fg0, fg1});
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    clk_step();
  endtask

  task automatic test_byte_sign();
    drv1(1'b1, 32'h4, 32'h123456A5, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
    clk_step();
    n_checks++;
    if ({g1, we_s, size_s, wd_s[7:0]} !== {1'b1, 1'b1, 2'b00, 8'hA5}) begin
      n_fail++; $display("FAIL byte_store got g1=%b we=%b size=%b wd=%h exp 1 1 00 a5",
                         g1, we_s, size_s, wd_s[7:0]);
    end
    m1_req = 1'b0;
    drv0(1'b1, 32'h4, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'hFFFFFFA5);
    clk_step();
    drv0(1'b1, 32'h4, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h000000A5);
    clk_step();
    m0_req = 1'b0;
    clk_step();
  endtask

  task automatic test_back_to_back();
    drv0(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      clk_step();
      n_checks++;
      if (g0 !== 1'b1) begin
        n_fail++; $display("FAIL b2b_gnt cycle %0d got=%b exp=1", i, g0);
      end
    end
    m0_req = 1'b0;
    clk_step();
  endtask

  task automatic test_misalign();
    drv0(1'b1, 32'h8, 32'h00001234, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0);
    clk_step();
    drv0(1'b1, 32'h9, 32'h0000BEEF, 2'b01, 1'b0, 1'b1, 1'b1, 32'h0);
    clk_step();
    n_checks++;
    if ({g0, we_s} !== 2'b10) begin
      n_fail++; $display("FAIL misalign_we got g0we=%b exp=10", {g0, we_s});
    end
    drv0(1'b1, 32'h8, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h00001234);
    clk_step();
    drv0(1'b1, 32'h0, 32'h0, 2'b11, 1'b0, 1'b1, 1'b1, 32'h0);
    clk_step();
    n_checks++;
    if (we_s !== 1'b0) begin
      n_fail++; $display("FAIL illegal_size_we got=%b exp=0", we_s);
    end
    drv0(1'b1, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 32'h0);
    clk_step();
    drv0(1'b1, 32'h2, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0);
    clk_step();
    drv0(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    clk_step();
    m0_req = 1'b0;
    clk_step();
  endtask

  task automatic test_idle();
    drv0(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    clk_step();
    m0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      n_checks++;
      if ({g0, g1, we_s, size_s, a_s, wd_s} !== {1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0}) begin
        n_fail++; $display("FAIL idle cycle %0d got g0=%b g1=%b we=%b size=%b a=%h wd=%h exp 0 0 0 10 0 0",
                           i, g0, g1, we_s, size_s, a_s, wd_s);
      end
    end
    drv0(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    drv1(1'b1, 32'h4, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h000000A5);
    clk_step();
    n_checks++;
    if ({g0, g1} !== 2'b01) begin
      n_fail++; $display("FAIL idle_rr got g0g1=%b exp=01", {g0, g1});
    end
    m1_req = 1'b0;
    clk_step();
    n_checks++;
    if ({g0, g1} !== 2'b10) begin
      n_fail++; $display("FAIL wait_served got g0g1=%b exp=10", {g0, g1});
    end
    m0_req = 1'b0;
    clk_step();
  endtask

  task automatic test_reset_mid();
    drv0(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++;
    if (m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_gnt got=%b exp=1", m0_gnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    m0_req = 1'b0;
    drv1(1'b1, 32'h10, 32'hCAFEF00D, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    n_checks++;
    if ({m0_rvalid, mem_we} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_async got rvalid,we=%b exp=00", {m0_rvalid, mem_we});
    end
    #2;
    m1_req = 1'b0;
    rst = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0;
    q0.delete(); q1.delete();
    @(negedge clk);
    n_checks++;
    if ({m0_rvalid, m0_err, m0_rdata} !== 34'h0) begin
      n_fail++; $display("FAIL rst_mid_rsp got rvalid=%b err=%b rdata=%h exp 0 0 0",
                         m0_rvalid, m0_err, m0_rdata);
    end
    @(posedge clk); #1;
    drv0(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    drv1(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    clk_step();
    n_checks++;
    if ({g0, g1} !== 2'b10) begin
      n_fail++; $display("FAIL rst_first_conflict got g0g1=%b exp=10", {g0, g1});
    end
    m0_req = 1'b0;
    clk_step();
    m1_req = 1'b0;
    clk_step();
  endtask

  initial begin
    rst = 1'b1;
    pend0 = 1'b0; pend1 = 1'b0;
    exp0 = '0; exp1 = '0;
    test_reset();
    test_store_load();
    test_round_robin();
    test_byte_sign();
    test_back_to_back();
    test_misalign();
    test_idle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
